writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges the two result sources of the core, the ALU/execute path and the data-memory load-response path, onto the single write port of the register file. Each source has its own 2-entry FIFO with a valid/ready handshake. A fixed-priority arbiter with anti-starvation picks one entry per cycle. The winning entry drives registered `wr_en`/`wr_reg`/`wr_data` straight into the register file's write port.

## Interface
- `DATA_WIDTH`, 32, width of write data.
- `REG_ADDR_WIDTH`, 5, register index width (32 architectural registers).
- `STARVE_LIMIT`, 3, number of consecutive cycles the ALU head may lose arbitration before it is forced through (range 1..15).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU FIFO can accept.
- `alu_rd`  in  REG_ADDR_WIDTH  ALU destination register.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  MEM FIFO can accept.
- `mem_rd`  in  REG_ADDR_WIDTH  load destination register.
- `mem_data`  in  DATA_WIDTH  load data.
- `wr_en`  out  1  register-file write enable.
- `wr_reg`  out  REG_ADDR_WIDTH  register-file write index.
- `wr_data`  out  DATA_WIDTH  register-file write data.
- `busy`  out  1  any FIFO non-empty, or `wr_en` high.

## Operation
- **Handshake.** A transfer occurs on a rising edge where `valid && ready`.
  - `ready` is `!rst && (count < 2)`, based on the registered count only.
  - A full FIFO never accepts a push in the same cycle it pops.
- **FIFOs.** Each FIFO is 2 entries deep, strict in-order, with a 2-bit count.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo 2.
- **Arbitration.** Evaluated every cycle on the FIFO heads.
  - Only one FIFO non-empty: that FIFO pops.
  - Both non-empty: MEM pops, unless `starve_cnt == STARVE_LIMIT`, in which case ALU pops.
  - Both empty: nothing pops.
- **Starve counter.** Saturating, 4 bits wide.
  - Increments when the ALU is non-empty and MEM wins.
  - Clears when the ALU pops, or when the ALU FIFO is empty.
- **Output register.** Updates on every edge.
  - If an entry pops with rd != 0: `wr_en`=1, and `wr_reg`/`wr_data` take the entry's rd and data.
  - If an entry pops with rd == 0: the entry is discarded, `wr_en`=0, and `wr_reg`/`wr_data` hold their previous values. The slot is still consumed.
  - If nothing pops: `wr_en`=0, and `wr_reg`/`wr_data` hold.
- **Ordering.** At most one write per cycle. Program ordering between the two sources is not enforced here; the hazard unit upstream guarantees it.

## Timing
- **Reset.** While `rst` is high, all state clears asynchronously:
  - FIFO counts and pointers = 0, `starve_cnt` = 0.
  - `wr_en`=0, `wr_reg`=0, `wr_data`=0.
  - `alu_ready`=`mem_ready`=0, `busy`=0.
- **Reset released.** Both ready outputs go to 1 combinationally.
- **Reset mid-operation.** Queued entries are dropped, and `wr_en` falls immediately without waiting for a clock edge.
- **Latency.** An entry accepted into an empty, uncontested FIFO at edge N pops at edge N+1, so `wr_en` is high during the cycle after N+1. The register file commits it at edge N+2.
- **Throughput.** One write per cycle total. A single source streaming with the other idle sustains 1 transfer per cycle, since ready stays high with count ≤ 1.
- **Backpressure.** With both sources streaming, ALU ready drops. The ALU is guaranteed one pop at least every `STARVE_LIMIT`+1 arbitrated cycles.
- **Full FIFO.** With both entries held and a pop this cycle, ready stays low this cycle and rises the next.

## Test plan
- **Reset state.** Assert `rst` asynchronously mid-cycle with both FIFOs holding entries -> `wr_en`, `wr_reg`, `wr_data`, `busy` and both ready outputs go to 0 immediately. After release, no stale write appears.
- **Single ALU write.** ALU pushes rd=5, data=32'hDEADBEEF at edge N -> `wr_en`=1, `wr_reg`=5, `wr_data`=DEADBEEF after edge N+1. A register file downstream reads DEADBEEF at x5 after edge N+2.
- **x0 discard.** MEM pushes rd=0, data=32'hFFFFFFFF -> the entry is consumed, `wr_en` stays 0, and `wr_reg`/`wr_data` keep their prior values. `busy` is high for exactly one cycle.
- **Priority and starvation.** Both sources hold `valid` continuously with `STARVE_LIMIT`=3 -> the pop sequence is MEM, MEM, MEM, ALU, repeating. No ALU gap exceeds 4 writes.
- **Backpressure.** MEM `valid` is held continuously and ALU pushes 3 entries back-to-back -> `alu_ready` falls after the 2nd accept. The 3rd is accepted one cycle after the first ALU pop. All 3 ALU writes appear in order with their correct data.
- **Scoreboarding against a reference model.** Run 1000 random valid patterns with random rd/data, checking against a queue-based reference model -> each source's write order is preserved, no write is lost or duplicated, no rd=0 write is issued, and at most one `wr_en` occurs per cycle.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Merges ALU and load-response results onto the single register-file write port.
// Each source has a 2-entry FIFO; MEM has fixed priority, ALU is forced through after STARVE_LIMIT losses.
module writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] wr_reg,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      busy
);

    localparam int ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Index 0 is the ALU source, index 1 the MEM source.
    logic [1:0]              in_valid;
    logic [1:0][ENTRY_W-1:0] in_entry;
    logic [1:0][ENTRY_W-1:0] head;
    logic [1:0]              ready;
    logic [1:0]              push;
    logic [1:0]              pop;
    logic [1:0]              non_empty;

    assign in_valid    = {mem_valid, alu_valid};
    assign in_entry[0] = {alu_rd, alu_data};
    assign in_entry[1] = {mem_rd, mem_data};
    assign alu_ready   = ready[0];
    assign mem_ready   = ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] store_reg [2];
            logic               wr_ptr_reg;
            logic               rd_ptr_reg;
            logic [1:0]         count_reg;

            assign ready[gi]     = !rst && (count_reg < 2'd2);
            assign push[gi]      = in_valid[gi] && ready[gi];
            assign non_empty[gi] = (count_reg != 2'd0);
            assign head[gi]      = store_reg[rd_ptr_reg];

            // Storage carries no reset so it can map onto plain distributed RAM.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    store_reg[wr_ptr_reg] <= in_entry[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= 1'b0;
                    rd_ptr_reg <= 1'b0;
                    count_reg  <= 2'd0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= ~wr_ptr_reg;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= ~rd_ptr_reg;
                    end
                    if (push[gi] && !pop[gi]) begin
                        count_reg <= count_reg + 2'd1;
                    end else if (!push[gi] && pop[gi]) begin
                        count_reg <= count_reg - 2'd1;
                    end
                end
            end
        end
    endgenerate

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;
    logic       pop_alu;
    logic       pop_mem;

    assign pop_alu = non_empty[0] && (!non_empty[1] || (starve_cnt_reg == LIMIT));
    assign pop_mem = non_empty[1] && !pop_alu;
    assign pop     = {pop_mem, pop_alu};

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!non_empty[0] || pop_alu) begin
            starve_cnt_next = 4'd0;
        end else if (pop_mem && (starve_cnt_reg != 4'hF)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    logic [ENTRY_W-1:0]        pop_entry;
    logic [REG_ADDR_WIDTH-1:0] pop_rd;
    logic [DATA_WIDTH-1:0]     pop_data;
    logic                      wr_en_reg;
    logic [REG_ADDR_WIDTH-1:0] wr_reg_reg;
    logic [DATA_WIDTH-1:0]     wr_data_reg;

    assign pop_entry = pop_alu ? head[0] : head[1];
    assign pop_rd    = pop_entry[ENTRY_W-1:DATA_WIDTH];
    assign pop_data  = pop_entry[DATA_WIDTH-1:0];

    // Writes to x0 still consume the slot but leave the write port idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= 4'd0;
            wr_en_reg      <= 1'b0;
            wr_reg_reg     <= '0;
            wr_data_reg    <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            wr_en_reg      <= 1'b0;
            if ((pop_alu || pop_mem) && (pop_rd != '0)) begin
                wr_en_reg   <= 1'b1;
                wr_reg_reg  <= pop_rd;
                wr_data_reg <= pop_data;
            end
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_reg  = wr_reg_reg;
    assign wr_data = wr_data_reg;
    assign busy    = (|non_empty) || wr_en_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and random checks of writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic          busy;

    writeback_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Downstream register file
    logic [DW-1:0] rf [32];
    always @(posedge clk) begin
        if (wr_en === 1'b1) rf[wr_reg] <= wr_data;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    ent_t          aq[$];
    ent_t          mq[$];
    int            starve = 0;
    logic          exp_en = 1'b0;
    logic [AW-1:0] exp_reg = '0;
    logic [DW-1:0] exp_data = '0;
    int            exp_writes = 0;
    int            dut_writes = 0;
    logic          dut_src[$];
    logic [DW-1:0] dut_alu[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        mq.delete();
        starve   = 0;
        exp_en   = 1'b0;
        exp_reg  = '0;
        exp_data = '0;
    endtask

    // One clock: predict from inputs and model state, advance edge, compare.
    task automatic step();
        bit   acc_a, acc_m, a_ne, m_ne, take_a, take_m;
        ent_t e;
        chk("alu_ready", alu_ready, aq.size() < 2);
        chk("mem_ready", mem_ready, mq.size() < 2);
        acc_a  = alu_valid && (aq.size() < 2);
        acc_m  = mem_valid && (mq.size() < 2);
        a_ne   = aq.size() > 0;
        m_ne   = mq.size() > 0;
        take_a = a_ne && (!m_ne || starve == LIMIT);
        take_m = m_ne && !take_a;
        exp_en = 1'b0;
        if (take_a || take_m) begin
            e = take_a ? aq.pop_front() : mq.pop_front();
            if (e.rd != 0) begin
                exp_en   = 1'b1;
                exp_reg  = e.rd;
                exp_data = e.data;
                exp_writes++;
            end
        end
        if (!a_ne || take_a) starve = 0;
        else if (starve < 15) starve++;
        if (acc_a) aq.push_back('{rd: alu_rd, data: alu_data});
        if (acc_m) mq.push_back('{rd: mem_rd, data: mem_data});
        @(posedge clk);
        #1;
        cyc++;
        chk("wr_en", wr_en, exp_en);
        chk("wr_reg", wr_reg, exp_reg);
        chk("wr_data", wr_data, exp_data);
        chk("busy", busy, (aq.size() > 0) || (mq.size() > 0) || exp_en);
        if (wr_en === 1'b1) begin
            dut_writes++;
            chk("no_x0_write", wr_reg == 0, 1'b0);
            dut_src.push_back(wr_reg[4]);
            if (wr_reg < 16) dut_alu.push_back(wr_data);
        end
        $display("cyc %0d: alu v%0b r%0b mem v%0b r%0b -> wr_en=%0b wr_reg=%0d wr_data=%08h busy=%0b",
                 cyc, alu_valid, alu_ready, mem_valid, mem_ready, wr_en, wr_reg, wr_data, busy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] bp_data [3];
        int            n_acc, first_alu, acc3;
        bit            acc_now;

        // Reset state
        #3;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        #19 rst = 1'b0;
        #1;
        chk("release_alu_ready", alu_ready, 1'b1);
        chk("release_mem_ready", mem_ready, 1'b1);
        model_reset();
        step();

        // Single ALU write and register-file commit
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        step();
        chk("single_wr_en", wr_en, 1'b1);
        chk("single_wr_reg", wr_reg, 5'd5);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        step();
        chk("rf_x5", rf[5], 32'hDEADBEEF);

        // x0 discard
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        step();
        mem_valid = 1'b0;
        chk("x0_busy_high", busy, 1'b1);
        step();
        chk("x0_wr_en", wr_en, 1'b0);
        chk("x0_wr_reg_hold", wr_reg, 5'd5);
        chk("x0_wr_data_hold", wr_data, 32'hDEADBEEF);
        chk("x0_busy_low", busy, 1'b0);

        // Priority and starvation: ALU rd in 1..15, MEM rd in 16..31
        dut_src.delete();
        alu_valid = 1'b1; mem_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            alu_rd = 5'($urandom_range(1, 15));  alu_data = $urandom;
            mem_rd = 5'($urandom_range(16, 31)); mem_data = $urandom;
            step();
        end
        chk("prio_count", dut_src.size(), 16);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("prio_src_%0d", i), dut_src[i], (i % 4 == 3) ? 1'b0 : 1'b1);
        end

        // Asynchronous reset mid-cycle with both FIFOs loaded
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wr_reg", wr_reg, 5'd0);
        chk("midrst_wr_data", wr_data, 32'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_alu_ready", alu_ready, 1'b0);
        chk("midrst_mem_ready", mem_ready, 1'b0);
        model_reset();
        #10 rst = 1'b0;
        #1;
        chk("midrst_release_ready", {alu_ready, mem_ready}, 2'b11);
        for (int i = 0; i < 3; i++) step();

        // Backpressure: MEM streams, ALU pushes three entries back-to-back
        for (int k = 0; k < 3; k++) bp_data[k] = $urandom;
        dut_alu.delete();
        n_acc = 0; first_alu = -1; acc3 = -1;
        mem_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (n_acc < 3) begin
                alu_valid = 1'b1; alu_rd = 5'(n_acc + 1); alu_data = bp_data[n_acc];
            end else begin
                alu_valid = 1'b0;
            end
            if (i >= 14) mem_valid = 1'b0;
            mem_rd = 5'($urandom_range(16, 31)); mem_data = $urandom;
            acc_now = alu_valid && (alu_ready === 1'b1);
            step();
            if (acc_now) begin
                n_acc++;
                if (n_acc == 2) chk("bp_ready_fall", alu_ready, 1'b0);
                if (n_acc == 3) acc3 = cyc;
            end
            if (first_alu < 0 && wr_en === 1'b1 && wr_reg < 16) first_alu = cyc;
        end
        chk("bp_accepts", n_acc, 3);
        chk("bp_third_accept", acc3, first_alu + 1);
        chk("bp_alu_writes", dut_alu.size(), 3);
        for (int k = 0; k < 3 && k < dut_alu.size(); k++) begin
            chk($sformatf("bp_order_%0d", k), dut_alu[k], bp_data[k]);
        end

        // Random traffic against the reference model
        exp_writes = 0; dut_writes = 0;
        for (int i = 0; i < 1000; i++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            mem_valid = ($urandom_range(0, 99) < 55);
            alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
            mem_rd = 5'($urandom_range(0, 31)); mem_data = $urandom;
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("rand_write_total", dut_writes, exp_writes);
        chk("rand_drained_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
